// File: rtl/radix_divider.sv
// Iterative restoring divider: STEPS quotient bits per clock, signed/unsigned,
// divide-by-zero short-cut and cancel support.
module radix_divider #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int ITERS = WIDTH / STEPS;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d, dz_q, dz_d;

  logic [WIDTH-1:0]   dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
  logic               sdiv_q, sdiv_d, s1_q, s1_d, s2_q, s2_d;

  logic [WIDTH-1:0]   mag1, mag2, rem_s, quo_s, q_fix, r_fix;
  logic [WIDTH:0]     tmp, diff;

  // -MIN wraps to MIN, which is exactly 2^(WIDTH-1) read as unsigned.
  assign mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  assign q_fix = (sdiv_q && (s1_q ^ s2_q)) ? -quo_q : quo_q;
  assign r_fix = (sdiv_q && s1_q) ? -rem_q : rem_q;

  // Borrow out of the WIDTH+1-bit subtract (diff[WIDTH]) means restore.
  always_comb begin
    rem_s = rem_q;
    quo_s = quo_q;
    tmp   = '0;
    diff  = '0;
    for (int s = 0; s < STEPS; s++) begin
      tmp   = {rem_s, quo_s[WIDTH-1]};
      diff  = tmp - {1'b0, dvs_q};
      quo_s = {quo_s[WIDTH-2:0], ~diff[WIDTH]};
      rem_s = diff[WIDTH] ? tmp[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ready_d  = ready_q;
    dz_d     = dz_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    sdiv_d   = sdiv_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          sdiv_d = signed_div_i;
          s1_d   = opdata1_i[WIDTH-1];
          s2_d   = opdata2_i[WIDTH-1];
          quo_d  = mag1;
          rem_d  = '0;
          dvs_d  = mag2;
          cnt_d  = '0;
          if (opdata2_i == '0) begin
            state_d  = DONE;
            result_d = {opdata1_i, {WIDTH{1'b1}}};
            ready_d  = 1'b1;
            dz_d     = 1'b1;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = rem_s;
          quo_d = quo_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d  = DONE;
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
          dz_d     = 1'b0;
        end
      end
      DONE: begin
        if (!start_i) begin
          state_d  = IDLE;
          result_d = '0;
          ready_d  = 1'b0;
          dz_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      dz_q     <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    dvs_q  <= dvs_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    sdiv_q <= sdiv_d;
    s1_q   <= s1_d;
    s2_q   <= s2_d;
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign div_zero_o = dz_q;
  assign busy_o     = (state_q == CALC) || (state_q == FIX);

endmodule

// File: tb/tb_radix_divider.sv
// Directed bench for radix_divider: 32-bit/1-step and 16-bit/4-step instances.
module tb_radix_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start, annul, sdiv;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic        ready, busy, dz;
  logic        start16, annul16, sdiv16;
  logic [15:0] a16, b16;
  logic [31:0] result16;
  logic        ready16, busy16, dz16;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  radix_divider #(.WIDTH(32), .STEPS(1)) dut (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .signed_div_i(sdiv),
    .opdata1_i(op1), .opdata2_i(op2), .result_o(result), .ready_o(ready),
    .busy_o(busy), .div_zero_o(dz));

  radix_divider #(.WIDTH(16), .STEPS(4)) dut16 (
    .clk(clk), .rst(rst), .start_i(start16), .annul_i(annul16), .signed_div_i(sdiv16),
    .opdata1_i(a16), .opdata2_i(b16), .result_o(result16), .ready_o(ready16),
    .busy_o(busy16), .div_zero_o(dz16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Operands are scrambled right after acceptance; the result must not care.
  task automatic div32(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic keep, output logic [63:0] res, output logic dzo,
                       output int lat);
    @(negedge clk); op1 = a; op2 = b; sdiv = sg; start = 1'b1; lat = 0;
    @(negedge clk); lat = 1; op1 = ~a; op2 = '0; sdiv = ~sg;
    while (!ready && lat < 100) begin @(negedge clk); lat++; end
    res = result; dzo = dz;
    if (!keep) begin start = 1'b0; @(negedge clk); end
  endtask

  task automatic div16(input logic [15:0] a, input logic [15:0] b, input logic sg,
                       output logic [31:0] res, output logic dzo, output int lat);
    @(negedge clk); a16 = a; b16 = b; sdiv16 = sg; start16 = 1'b1; lat = 0;
    @(negedge clk); lat = 1; a16 = ~a; b16 = 16'h0001; sdiv16 = ~sg;
    while (!ready16 && lat < 50) begin @(negedge clk); lat++; end
    res = result16; dzo = dz16;
    start16 = 1'b0; @(negedge clk);
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic sg);
    int sa, sb, q, r;
    if (b == 16'd0) return {a, 16'hFFFF};
    if (sg) begin
      sa = int'($signed(a)); sb = int'($signed(b));
      q = sa / sb; r = sa % sb;
      return {r[15:0], q[15:0]};
    end
    return {a % b, a / b};
  endfunction

  initial begin
    logic [63:0] r;
    logic [31:0] r16, e16;
    logic        d;
    int          l;
    logic        seen;
    logic [15:0] ra, rb;
    logic        rs;
    start = 0; annul = 0; sdiv = 0; op1 = '0; op2 = '0;
    start16 = 0; annul16 = 0; sdiv16 = 0; a16 = '0; b16 = '0;

    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk); rst = 1'b0;

    div32(32'd100, 32'd7, 1'b0, 1'b0, r, d, l);
    chk("u100_7", r, {32'd2, 32'd14});
    chk("u100_7_lat", 64'(l), 64'd34);
    chk("u100_7_dz", 64'(d), 64'd0);
    chk("u100_7_clr_rdy", 64'(ready), 64'd0);
    chk("u100_7_clr_res", result, 64'd0);

    div32(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, r, d, l);
    chk("s_m7_2", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    div32(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, r, d, l);
    chk("s_7_m2", r, {32'h0000_0001, 32'hFFFF_FFFD});
    div32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, r, d, l);
    chk("s_min_m1", r, {32'h0, 32'h8000_0000});
    chk("s_min_m1_dz", 64'(d), 64'd0);
    div32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, r, d, l);
    chk("u_min_m1", r, {32'h8000_0000, 32'h0});
    div32(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, r, d, l);
    chk("u_max_1", r, {32'h0, 32'hFFFF_FFFF});
    div32(32'd5, 32'd9, 1'b0, 1'b0, r, d, l);
    chk("u_5_9", r, {32'd5, 32'd0});

    div32(32'h1234, 32'h0, 1'b0, 1'b1, r, d, l);
    chk("dz_res", r, {32'h1234, 32'hFFFF_FFFF});
    chk("dz_flag", 64'(d), 64'd1);
    chk("dz_lat", 64'(l), 64'd1);
    repeat (3) @(negedge clk);
    chk("dz_hold_res", result, {32'h1234, 32'hFFFF_FFFF});
    chk("dz_hold_rdy", 64'(ready), 64'd1);
    chk("dz_hold_busy", 64'(busy), 64'd0);
    start = 1'b0; @(negedge clk);
    chk("dz_clr_rdy", 64'(ready), 64'd0);
    chk("dz_clr_dz", 64'(dz), 64'd0);
    chk("dz_clr_res", result, 64'd0);

    div32(32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, r, d, l);
    chk("dz_signed_res", r, {32'hFFFF_FFF0, 32'hFFFF_FFFF});

    // cancel partway through CALC
    @(negedge clk); op1 = 32'd100; op2 = 32'd7; sdiv = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    chk("annul_busy_pre", 64'(busy), 64'd1);
    annul = 1'b1; @(negedge clk); annul = 1'b0;
    chk("annul_busy_post", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ready) seen = 1'b1; end
    chk("annul_no_ready", 64'(seen), 64'd0);

    // start with annul held must not launch
    @(negedge clk); op2 = 32'd3; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    chk("annul_start_busy", 64'(busy), 64'd0);
    start = 1'b0; annul = 1'b0;

    // reset between edges mid-CALC
    @(negedge clk); op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstcalc_busy_pre", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstcalc_busy", 64'(busy), 64'd0);
    chk("rstcalc_ready", 64'(ready), 64'd0);
    @(negedge clk); rst = 1'b0;
    div32(32'd9, 32'd3, 1'b0, 1'b0, r, d, l);
    chk("post_rst_9_3", r, {32'd0, 32'd3});
    chk("post_rst_lat", 64'(l), 64'd34);

    // reset between edges while holding DONE
    div32(32'd100, 32'd7, 1'b0, 1'b1, r, d, l);
    chk("done_pre_rst", 64'(ready), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstdone_ready", 64'(ready), 64'd0);
    chk("rstdone_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk); rst = 1'b0;

    // 16-bit, 4 bits per cycle
    div16(16'h8000, 16'hFFFF, 1'b1, r16, d, l);
    chk("w16_min_m1", 64'(r16), 64'(32'h0000_8000));
    chk("w16_min_m1_lat", 64'(l), 64'd6);
    div16(16'h00AB, 16'h0000, 1'b0, r16, d, l);
    chk("w16_dz", 64'(r16), 64'(32'h00AB_FFFF));
    chk("w16_dz_lat", 64'(l), 64'd1);
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom);
      if (i % 2 == 1) rb = -rb;
      rs = 1'($urandom_range(0, 1));
      e16 = ref16(ra, rb, rs);
      div16(ra, rb, rs, r16, d, l);
      chk($sformatf("w16_rand%0d_%h_%h_%0d", i, ra, rb, rs), 64'(r16), 64'(e16));
      chk($sformatf("w16_rand%0d_lat", i), 64'(l), (rb == 16'd0) ? 64'd1 : 64'd6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/radix_divider.md
RADIX_DIVIDER -- requirements
Module: radix_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal values 8..64.
REQ-002 Parameter STEPS, default 1: quotient bits retired per clock; legal values 1, 2, 4; WIDTH % STEPS SHALL be 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start_i  input  1  level request; operands sampled on the accepting edge.
REQ-006 annul_i  input  1  cancel the in-flight divide.
REQ-007 signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-008 opdata1_i  input  WIDTH  dividend.
REQ-009 opdata2_i  input  WIDTH  divisor.
REQ-010 result_o  output  2*WIDTH  {remainder, quotient}; all zeros unless ready_o = 1.
REQ-011 ready_o  output  1  result valid.
REQ-012 busy_o  output  1  high in CALC and FIX.
REQ-013 div_zero_o  output  1  qualifies ready_o; result came from a zero divisor.

Function
REQ-014 States are IDLE, CALC, FIX and DONE; there is no other state.
REQ-015 IDLE: start_i=1 and annul_i=0 SHALL latch opdata1_i, opdata2_i, signed_div_i and both operand signs into internal registers.
REQ-016 From IDLE, a zero divisor -> DONE; otherwise -> CALC with the iteration counter at 0.
REQ-017 All later sign decisions SHALL use the latched copies; input changes after acceptance are ignored.
REQ-018 Signed mode works on magnitudes (negate when the sign bit is 1); the most negative value maps to 2^(WIDTH-1) unsigned.
REQ-019 CALC: each cycle performs STEPS restoring shift-subtract steps using a WIDTH+1-bit subtractor per step; it runs exactly WIDTH/STEPS cycles, then -> FIX.
REQ-020 FIX: in signed mode, negate the quotient if the operand signs differ and negate the remainder if the dividend was negative; then -> DONE.
REQ-021 Signed overflow (MIN / -1) SHALL yield quotient = MIN and remainder = 0, with no flag.
REQ-022 Divide by zero SHALL yield quotient = all ones and remainder = the latched dividend, unmodified, with div_zero_o = 1.
REQ-023 ready_o, result_o and div_zero_o are registered; they become valid on the edge that enters DONE.
REQ-024 Latency, from the accepting edge to the first cycle with ready_o = 1: WIDTH/STEPS + 2 edges for a normal divide (34 at defaults) and 1 edge for divide by zero.
REQ-025 DONE: outputs hold while start_i = 1.
REQ-026 DONE: start_i = 0 -> IDLE, clearing result_o, ready_o and div_zero_o on that edge; a new start is accepted no earlier than the following edge.
REQ-027 annul_i = 1 in CALC or FIX -> IDLE on the next edge, with no ready_o pulse; annul_i is ignored in DONE.
REQ-028 annul_i = 1 together with start_i = 1 in IDLE SHALL NOT start a divide.
REQ-029 busy_o and ready_o are never high together.

Reset
REQ-030 rst = 1 SHALL immediately force IDLE, result_o = 0, ready_o = 0, busy_o = 0, div_zero_o = 0 and counter = 0, whatever the clock is doing.
REQ-031 Reset asserted mid-CALC discards the operation; after release, the first accepted start behaves exactly as from a fresh power-up.
REQ-032 Datapath registers other than the counter need no reset value.

Verification
REQ-033 WIDTH=32, STEPS=1, unsigned, 100/7 -> after 34 edges, ready_o=1, result_o = {32'd2, 32'd14}, div_zero_o=0.
REQ-034 Signed, -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned, same operands -> quotient 0, remainder 0x80000000.
REQ-036 Divisor 0, dividend 0x1234 -> after 1 edge ready_o=1, div_zero_o=1, result_o = {32'h1234, 32'hFFFFFFFF}; drop start_i -> all outputs 0 on the next edge.
REQ-037 annul_i pulsed in CALC cycle 10 -> IDLE, ready_o never asserts; rst pulsed mid-CALC, even between clock edges -> outputs 0 at once; a following 9/3 returns {0, 3}.
REQ-038 WIDTH=16, STEPS=4, random signed and unsigned operands checked against a reference model -> results match, and ready_o rises 6 edges after acceptance.
